md_alu_control: RTL and testbench
=================================

MD_ALU_CONTROL -- requirements
Module: md_alu_control

Interface
REQ-001 The module SHALL have parameter: WIDTH, 32, operand/HI/LO data width (legal 8..64, even).
REQ-002 The module SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 The module SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have port: ALUOP  input  2  main-control ALU opcode.
REQ-005 The module SHALL have port: Funcion  input  6  R-type funct field.
REQ-006 The module SHALL have port: start  input  1  issue strobe for the decoded instruction.
REQ-007 The module SHALL have port: op_a  input  WIDTH  rs operand (multiplicand/dividend).
REQ-008 The module SHALL have port: op_b  input  WIDTH  rt operand (multiplier/divisor).
REQ-009 The module SHALL have port: ALU_Control  output  4  ALU operation select.
REQ-010 The module SHALL have port: busy  output  1  multiply/divide in progress.
REQ-011 The module SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 The module SHALL have port: stall  output  1  pipeline hold request.
REQ-013 The module SHALL have port: md_result  output  WIDTH  HI for MFHI, LO for MFLO, else 0.
REQ-014 The module SHALL have port: hi  output  WIDTH  HI register.
REQ-015 The module SHALL have port: lo  output  WIDTH  LO register.

Function
REQ-016 ALU_Control SHALL be combinational: ALUOP 00 -> 0010; 01 -> 0110; 11 -> 1111.
REQ-017 ALUOP 10 SHALL decode Funcion: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 (NOR) -> 1100.
REQ-018 ALUOP 10 with MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010 or any undefined funct SHALL give ALU_Control 1111; the output SHALL never be latched.
REQ-019 md_op SHALL mean ALUOP=10 and Funcion in {MULTU, DIVU, MFHI, MFLO}.
REQ-020 FSM states SHALL be IDLE, MUL, DIV and FIN.
REQ-021 In IDLE, start=1 with ALUOP=10 and MULTU/DIVU SHALL capture op_a/op_b, clear the iteration counter and enter MUL/DIV at the next edge.
REQ-022 start with any other decode, or in any state other than IDLE, SHALL be ignored; no state or HI/LO change.
REQ-023 MUL SHALL run WIDTH cycles of unsigned shift-add, one multiplier bit per cycle, forming a 2*WIDTH product.
REQ-024 DIV SHALL run WIDTH cycles of unsigned restoring division, one quotient bit per cycle.
REQ-025 The counter SHALL be $clog2(WIDTH+1) bits wide. On the WIDTH-th iteration edge, hi/lo SHALL load the result: MUL hi=product[2W-1:W], lo=product[W-1:0]; DIV lo=quotient, hi=remainder. The FSM then enters FIN.
REQ-026 FIN SHALL last exactly one cycle with done=1, then return to IDLE. done SHALL be 0 in all other states.
REQ-027 busy SHALL be 1 exactly in MUL and DIV.
REQ-028 Latency SHALL be fixed: start accepted at edge 0, busy on cycles 1..WIDTH, done and new hi/lo visible on cycle WIDTH+1.
REQ-029 Divisor 0 SHALL not trap and SHALL take the same WIDTH cycles, giving lo=all ones and hi=dividend.
REQ-030 hi and lo SHALL change only at the completion edge or on reset.
REQ-031 stall SHALL be combinational: busy AND md_op, i.e. hold MFHI/MFLO/new MULTU/DIVU while an operation is running. stall SHALL be 0 in FIN and IDLE.
REQ-032 md_result SHALL be combinational from the current hi/lo. MFHI/MFLO in FIN SHALL see the freshly written values.
REQ-033 Operand inputs SHALL be ignored after capture; changing op_a/op_b mid-operation SHALL not affect the result.

Reset
REQ-034 Reset=1 at a rising edge SHALL force IDLE, counter 0, and hi=lo=0. The resulting outputs SHALL be busy=0, done=0 and stall=0.
REQ-035 Reset mid-operation SHALL abort the operation with no hi/lo update and no done pulse. Reset SHALL take priority over start and completion in the same cycle.
REQ-036 ALU_Control SHALL be independent of reset.

Verification
REQ-037 With WIDTH=32, a bench SHALL cover: MULTU a=FFFFFFFF, b=2 -> busy cycles 1..32; done on cycle 33; hi=00000001, lo=FFFFFFFE.
REQ-038 With WIDTH=32, a bench SHALL cover: DIVU a=100, b=7 -> lo=14, hi=2 on cycle 33; then MFLO -> md_result=14 and ALU_Control=1111.
REQ-039 With WIDTH=32, a bench SHALL cover: DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678, latency 33.
REQ-040 With WIDTH=32, a bench SHALL cover: reset on cycle 10 of a MULTU -> next cycle busy=0, hi=lo=0; done never asserted.
REQ-041 With WIDTH=32, a bench SHALL cover: MFHI and a second MULTU start presented while busy -> stall=1 and the start is ignored. With an ADD during busy -> stall=0 and ALU_Control=0010.
REQ-042 With WIDTH=32, a bench SHALL cover: a decode sweep over all ALUOP and Funcion combinations -> matches REQ-016..018, with undefined funct giving 1111. The sweep SHALL be repeated at WIDTH=8 with MULTU 0xFF*0xFF -> hi=FE, lo=01 on cycle 9.

Source files
------------

// File: rtl/md_alu_control.sv
// rtl/md_alu_control.sv - ALU control decode with iterative unsigned multiply/divide unit and HI/LO registers
module md_alu_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOP,
    input  logic [5:0]       Funcion,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       ALU_Control,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] md_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  opnd;
    // MUL: {partial product high half, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_nxt;

    logic             rtype;
    logic             issue_mul;
    logic             issue_div;
    logic             last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign rtype     = (ALUOP == 2'b10);
    assign issue_mul = start && rtype && (Funcion == F_MULTU);
    assign issue_div = start && rtype && (Funcion == F_DIVU);
    assign last      = (cnt == CW'(WIDTH - 1));

    always_comb begin
        ALU_Control = 4'b1111;
        case (ALUOP)
            2'b00: ALU_Control = 4'b0010;
            2'b01: ALU_Control = 4'b0110;
            2'b10: begin
                case (Funcion)
                    F_ADD:   ALU_Control = 4'b0010;
                    F_SUB:   ALU_Control = 4'b0110;
                    F_AND:   ALU_Control = 4'b0000;
                    F_OR:    ALU_Control = 4'b0001;
                    F_SLT:   ALU_Control = 4'b0111;
                    F_NOR:   ALU_Control = 4'b1100;
                    default: ALU_Control = 4'b1111;
                endcase
            end
            default: ALU_Control = 4'b1111;
        endcase
    end

    // One shift-add or one restoring-subtract step per cycle
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (state == MUL) begin
            step_nxt = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            step_nxt = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_mul)      state_nxt = MUL;
                else if (issue_div) state_nxt = DIV;
            end
            MUL, DIV: begin
                if (last) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == MUL) || (state == DIV);
    assign done  = (state == FIN);
    assign stall = busy && rtype &&
                   ((Funcion == F_MULTU) || (Funcion == F_DIVU) ||
                    (Funcion == F_MFHI)  || (Funcion == F_MFLO));

    always_comb begin
        md_result = '0;
        if (rtype && (Funcion == F_MFHI))      md_result = hi;
        else if (rtype && (Funcion == F_MFLO)) md_result = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            opnd  <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (issue_mul || issue_div) begin
                    cnt  <= '0;
                    opnd <= issue_mul ? op_a : op_b;
                    acc  <= {{WIDTH{1'b0}}, (issue_mul ? op_b : op_a)};
                end
            end else if (busy) begin
                cnt <= cnt + CW'(1);
                acc <= step_nxt;
                if (last) begin
                    hi <= step_nxt[2*WIDTH-1:WIDTH];
                    lo <= step_nxt[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_md_alu_control.sv
// tb/tb_md_alu_control.sv - self-checking bench for md_alu_control at WIDTH=32 and WIDTH=8
module tb_md_alu_control;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk;
    logic        reset;
    logic [1:0]  ALUOP;
    logic [5:0]  Funcion;
    logic        start;
    logic [31:0] op_a, op_b;
    logic [3:0]  ALU_Control;
    logic        busy, done, stall;
    logic [31:0] md_result, hi, lo;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [3:0]  alu8;
    logic        busy8, done8, stall8;
    logic [7:0]  mdr8, hi8, lo8;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    md_alu_control #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ALUOP(ALUOP), .Funcion(Funcion), .start(start),
        .op_a(op_a), .op_b(op_b), .ALU_Control(ALU_Control), .busy(busy), .done(done),
        .stall(stall), .md_result(md_result), .hi(hi), .lo(lo)
    );

    md_alu_control #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .ALUOP(ALUOP), .Funcion(Funcion), .start(start8),
        .op_a(a8), .op_b(b8), .ALU_Control(alu8), .busy(busy8), .done(done8),
        .stall(stall8), .md_result(mdr8), .hi(hi8), .lo(lo8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_alu(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b1111;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic bit is_md(input logic [1:0] op, input logic [5:0] f);
        return (op == 2'b10) && (f == F_MULTU || f == F_DIVU || f == F_MFHI || f == F_MFLO);
    endfunction

    // Reference: an operation is a countdown of 32 busy cycles followed by one done cycle
    int          m_left = 0;
    bit          m_fin  = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    logic [63:0] prod;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_fin = 0; m_hi = 0; m_lo = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_fin = 1;
            end
        end else if (start && ALUOP == 2'b10 && (Funcion == F_MULTU || Funcion == F_DIVU)) begin
            if (Funcion == F_MULTU) begin
                prod = {32'b0, op_a} * {32'b0, op_b};
                p_hi = prod[63:32]; p_lo = prod[31:0];
            end else if (op_b == 0) begin
                p_hi = op_a; p_lo = 32'hFFFF_FFFF;
            end else begin
                p_hi = op_a % op_b; p_lo = op_a / op_b;
            end
            m_left = 32;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_busy", busy, m_left > 0);
            chk("m_done", done, m_fin);
            chk("m_stall", stall, (m_left > 0) && is_md(ALUOP, Funcion));
            chk("m_hi", hi, m_hi);
            chk("m_lo", lo, m_lo);
            chk("m_alu", ALU_Control, exp_alu(ALUOP, Funcion));
            chk("m_mdres", md_result,
                (ALUOP == 2'b10 && Funcion == F_MFHI) ? m_hi :
                (ALUOP == 2'b10 && Funcion == F_MFLO) ? m_lo : 32'h0);
        end
    end

    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk); #1;
        ALUOP = 2'b10; Funcion = f; start = 1; op_a = a; op_b = b;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(posedge clk); #1;
            op_a = $urandom; op_b = $urandom;
            start = (cyc == 5 || cyc == 6);
            ALUOP = 2'b00; Funcion = 6'd0;
            if (cyc == 5) begin
                ALUOP = 2'b10; Funcion = F_MFHI;
            end else if (cyc == 6) begin
                ALUOP = 2'b10; Funcion = F_MULTU;
            end else if (cyc == 7) begin
                ALUOP = 2'b10; Funcion = F_ADD;
            end
            @(negedge clk);
            chk("lat_busy", busy, 1);
            chk("lat_done", done, 0);
            if (cyc == 5 || cyc == 6) chk("stall_md_busy", stall, 1);
            if (cyc == 7) begin
                chk("stall_add_busy", stall, 0);
                chk("alu_add_busy", ALU_Control, 4'b0010);
            end
        end
        @(posedge clk); #1;
        start = 0; ALUOP = 2'b10; Funcion = F_MFLO;
        @(negedge clk);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_stall", stall, 0);
        chk("fin_hi", hi, exp_hi);
        chk("fin_lo", lo, exp_lo);
        chk("fin_mflo", md_result, exp_lo);
        chk("fin_alu_mflo", ALU_Control, 4'b1111);
        @(posedge clk); #1;
        Funcion = F_MFHI;
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_mfhi", md_result, exp_hi);
        @(posedge clk); #1;
        ALUOP = 2'b00; Funcion = 6'd0;
    endtask

    task automatic reset_mid;
        @(posedge clk); #1;
        ALUOP = 2'b10; Funcion = F_MULTU; start = 1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5679;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            start = 0; ALUOP = 2'b00; Funcion = 6'd0;
            if (cyc == 10) reset = 1;
            @(negedge clk);
            chk("abort_busy_before", busy, 1);
        end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
    endtask

    task automatic run8;
        @(posedge clk); #1;
        ALUOP = 2'b10; Funcion = F_MULTU; start8 = 1; a8 = 8'hFF; b8 = 8'hFF;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); Funcion = F_MFHI;
            @(negedge clk);
            chk("w8_busy", busy8, 1);
            chk("w8_stall", stall8, 1);
            chk("w8_done", done8, 0);
        end
        @(posedge clk); #1;
        Funcion = F_MFLO;
        @(negedge clk);
        chk("w8_fin_done", done8, 1);
        chk("w8_fin_stall", stall8, 0);
        chk("w8_hi", hi8, 8'hFE);
        chk("w8_lo", lo8, 8'h01);
        chk("w8_mflo", mdr8, 8'h01);
        @(posedge clk); #1;
        ALUOP = 2'b00; Funcion = 6'd0;
        @(negedge clk);
        chk("w8_idle_done", done8, 0);
        chk("w8_idle_busy", busy8, 0);
    endtask

    initial begin
        reset = 1; start = 0; ALUOP = 2'b00; Funcion = 6'd0; op_a = 0; op_b = 0;
        start8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        cmp_en = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy8", busy8, 0);

        run_md(F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_md(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md(F_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        reset_mid();
        run8();

        for (int a = 0; a < 4; a++) begin
            for (int f = 0; f < 64; f++) begin
                @(posedge clk); #1;
                ALUOP = 2'(a); Funcion = 6'(f);
                #1;
                chk("sweep32", ALU_Control, exp_alu(2'(a), 6'(f)));
                chk("sweep8", alu8, exp_alu(2'(a), 6'(f)));
            end
        end

        for (int i = 0; i < 3000; i++) begin
            int sel;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            ALUOP = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom);
            sel = $urandom_range(0, 7);
            Funcion = (sel < 2) ? F_MULTU : (sel < 4) ? F_DIVU : (sel == 4) ? F_MFHI :
                      (sel == 5) ? F_MFLO : 6'($urandom);
            start = ($urandom_range(0, 2) == 0);
            op_a = $urandom;
            op_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        end
        @(posedge clk); #1;
        reset = 0; start = 0; ALUOP = 2'b00; Funcion = 6'd0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
